// File: rtl/exe_ctrl.sv
// exe_ctrl: execute-stage pipeline control.
// Arbitrates between memory back-pressure, iterative multi-cycle ALU ops,
// taken jumps and load-use hazards, and produces the per-stage stall/flush
// vectors (bit0 pc, 1 if_id, 2 id_exe, 3 exe_mem, 4 mem_wb), the pc redirect,
// the go/valid handshake to the multi-cycle unit and a stall-cycle counter.
//
// Multi-cycle handshake: mc_go_o is a one-cycle start pulse issued from IDLE
// when mc_req_i is seen and memory is not busy; the unit then runs for
// MC_CYCLES cycles (or until mc_done_i), and mc_valid_o is held in DONE until
// exe_mem can capture it (i.e. until mem_busy_i is low).
module exe_ctrl #(
   parameter int unsigned MC_CYCLES = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        jumpe_i,
   input  logic [31:0] jump_addr_i,
   input  logic        exe_mem_re_i,
   input  logic        exe_reg_we_i,
   input  logic [4:0]  exe_reg_waddr_i,
   input  logic        id_rs1_re_i,
   input  logic        id_rs2_re_i,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic        mc_req_i,
   input  logic        mc_done_i,
   input  logic        mem_busy_i,
   output logic [4:0]  stall_o,
   output logic [4:0]  flush_o,
   output logic        jump_o,
   output logic [31:0] jump_addr_o,
   output logic        mc_go_o,
   output logic        mc_valid_o,
   output logic [31:0] stall_cnt_o
);

   localparam int unsigned CW = $clog2(MC_CYCLES + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(MC_CYCLES - 1);

   localparam logic [4:0] ST_ALL   = 5'b11111;
   localparam logic [4:0] ST_MC    = 5'b00111;
   localparam logic [4:0] FL_MC    = 5'b01000;
   localparam logic [4:0] FL_JUMP  = 5'b00110;
   localparam logic [4:0] ST_LOAD  = 5'b00011;
   localparam logic [4:0] FL_LOAD  = 5'b00100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    stall_cnt_q, stall_cnt_d;
   logic           load_use;

   // Load-use hazard: a load in exe writes a register that id is reading now.
   always_comb begin
      load_use = exe_mem_re_i && exe_reg_we_i && (exe_reg_waddr_i != 5'd0) &&
                 ((id_rs1_re_i && (id_rs1_addr_i == exe_reg_waddr_i)) ||
                  (id_rs2_re_i && (id_rs2_addr_i == exe_reg_waddr_i)));
   end

   // State register, down-counter and stall counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Next state: the unit free-runs, so RUN advances even under mem_busy_i;
   // only the DONE->IDLE hand-off waits for memory to accept the result.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_cnt_d = stall_cnt_q + {31'd0, (stall_o != 5'd0)};
      case (state_q)
         S_IDLE: begin
            if (mc_req_i && !mem_busy_i) begin
               state_d = S_RUN;
               cnt_d   = CNT_INIT;
            end
         end
         S_RUN: begin
            if ((cnt_q == '0) || mc_done_i) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            if (!mem_busy_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: fixed priority reset > mem busy > multi-cycle > jump > load-use.
   always_comb begin
      stall_o     = 5'd0;
      flush_o     = 5'd0;
      jump_o      = 1'b0;
      jump_addr_o = 32'd0;
      mc_go_o     = 1'b0;
      mc_valid_o  = 1'b0;
      if (rst_i) begin
         stall_o = 5'd0;
      end else if (mem_busy_i) begin
         stall_o    = ST_ALL;
         mc_valid_o = (state_q == S_DONE);
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mc_req_i) begin
                  mc_go_o = 1'b1;
                  stall_o = ST_MC;
                  flush_o = FL_MC;
               end else if (jumpe_i) begin
                  jump_o      = 1'b1;
                  jump_addr_o = jump_addr_i;
                  flush_o     = FL_JUMP;
               end else if (load_use) begin
                  stall_o = ST_LOAD;
                  flush_o = FL_LOAD;
               end
            end
            S_RUN: begin
               stall_o = ST_MC;
               flush_o = FL_MC;
            end
            S_DONE: begin
               mc_valid_o = 1'b1;
            end
            default: begin
               stall_o = 5'd0;
            end
         endcase
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule
